// File: rtl/fsm_pkg.sv
// Shared state encodings for the run-initiator and the worker-side FSMs.
package fsm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ISSUE  = 2'b01,
      WAIT   = 2'b10,
      FINISH = 2'b11
   } fsm_state_e;

   // Width of the WAIT timeout counter; wide enough for TIMEOUT_CYCLES up to 255.
   localparam int TMO_W = 8;

   function automatic logic state_is_busy(input fsm_state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/fsm_timeout_counter.sv
// WAIT-phase timeout counter: cleared on each issue, counts while waiting,
// flags expiry on the last allowed WAIT cycle (count == TIMEOUT_CYCLES-1).
module fsm_timeout_counter
   import fsm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic i_clock,
   input  logic i_reset_async,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TMO_W-1:0] LAST_COUNT = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] count;

   // Count register; the owning FSM leaves WAIT at expiry, so no saturation is needed.
   always_ff @(posedge i_clock or posedge i_reset_async) begin
      if (i_reset_async) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TMO_W'(1);
      end
   end

   assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/fsm_run_initiator.sv
// Batch run initiator: issues one run request per job to a worker FSM,
// waits for each completion with a per-job timeout, and reports the batch.
//
// state  | meaning
// IDLE   | waiting for i_start; counters hold last batch result
// ISSUE  | o_isRun pulse for the next job, timeout counter cleared
// WAIT   | waiting for i_done or timeout expiry
// FINISH | o_batch_done pulse, then back to IDLE
module fsm_run_initiator
   import fsm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic             i_clock,
   input  logic             i_reset_async,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_num_jobs,
   output logic             o_isRun,
   input  logic             i_done,
   output logic             o_busy,
   output logic             o_batch_done,
   output logic             o_timeout_err,
   output logic [CNT_W-1:0] o_jobs_done
);

   fsm_state_e       state_q;
   fsm_state_e       state_d;
   logic [CNT_W-1:0] num_jobs_q;
   logic [CNT_W-1:0] jobs_done_q;
   logic [CNT_W-1:0] jobs_done_inc;
   logic             timeout_err_q;
   logic             expired;

   assign jobs_done_inc = jobs_done_q + CNT_W'(1);

   fsm_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clock       (i_clock),
      .i_reset_async (i_reset_async),
      .clear         (state_q == ISSUE),
      .enable        (state_q == WAIT),
      .expired       (expired)
   );

   // State register.
   always_ff @(posedge i_clock or posedge i_reset_async) begin
      if (i_reset_async) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; a completion on the expiry cycle wins over the timeout.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = (i_num_jobs != '0) ? ISSUE : FINISH;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE:  state_d = WAIT;
         WAIT: begin
            if (i_done) begin
               state_d = (jobs_done_inc == num_jobs_q) ? FINISH : ISSUE;
            end else if (expired) begin
               state_d = FINISH;
            end else begin
               state_d = WAIT;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Batch bookkeeping: job count latch, completion counter, sticky timeout flag.
   always_ff @(posedge i_clock or posedge i_reset_async) begin
      if (i_reset_async) begin
         num_jobs_q    <= '0;
         jobs_done_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  num_jobs_q    <= i_num_jobs;
                  jobs_done_q   <= '0;
                  timeout_err_q <= 1'b0;
               end
            end
            WAIT: begin
               if (i_done) begin
                  jobs_done_q <= jobs_done_inc;
               end else if (expired) begin
                  timeout_err_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Moore outputs straight from the state register.
   assign o_isRun       = (state_q == ISSUE);
   assign o_busy        = state_is_busy(state_q);
   assign o_batch_done  = (state_q == FINISH);
   assign o_timeout_err = timeout_err_q;
   assign o_jobs_done   = jobs_done_q;

endmodule

// File: tb/tb_fsm_run_initiator.sv
// Bench for fsm_run_initiator: batches are described as per-job worker
// response delays; the expected pulse timeline is derived from those delays.
module tb_fsm_run_initiator;

   localparam int T     = 16;
   localparam int CNT_W = 8;

   logic             i_clock = 1'b0;
   logic             i_reset_async = 1'b0;
   logic             i_start = 1'b0;
   logic [CNT_W-1:0] i_num_jobs = '0;
   logic             o_isRun;
   logic             i_done = 1'b0;
   logic             o_busy;
   logic             o_batch_done;
   logic             o_timeout_err;
   logic [CNT_W-1:0] o_jobs_done;

   int checks   = 0;
   int failures = 0;

   // Per-job worker delay (cycles from o_isRun to i_done); > T means no response.
   int dly [8];
   int exp_jobs = 0;
   bit exp_err  = 1'b0;

   fsm_run_initiator #(
      .TIMEOUT_CYCLES (T),
      .CNT_W          (CNT_W)
   ) dut (
      .i_clock       (i_clock),
      .i_reset_async (i_reset_async),
      .i_start       (i_start),
      .i_num_jobs    (i_num_jobs),
      .o_isRun       (o_isRun),
      .i_done        (i_done),
      .o_busy        (o_busy),
      .o_batch_done  (o_batch_done),
      .o_timeout_err (o_timeout_err),
      .o_jobs_done   (o_jobs_done)
   );

   always #5 i_clock = ~i_clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Caller is at posedge+1. Runs one batch of n jobs using dly[], checking the
   // timeline cycle by cycle. abort_cycle>0 asserts reset in that cycle instead.
   task automatic run_batch(input string name, input int n, input bit stray_start,
                            input int abort_cycle);
      bit run_at  [0:1023];
      bit done_at [0:1023];
      int r, bd, jobs, stray_t;
      bit err;
      foreach (run_at[i]) begin
         run_at[i]  = 1'b0;
         done_at[i] = 1'b0;
      end
      r = 1; jobs = 0; err = 1'b0; bd = 1;
      for (int k = 0; k < n; k++) begin
         run_at[r] = 1'b1;
         if (dly[k] > T) begin
            bd  = r + T + 1;
            err = 1'b1;
            break;
         end
         done_at[r + dly[k]] = 1'b1;
         jobs++;
         bd = r + dly[k] + 1;
         r  = bd;
      end
      stray_t = stray_start ? int'($urandom_range(bd, 1)) : -1;

      i_start    = 1'b1;
      i_num_jobs = CNT_W'(n);
      i_done     = 1'b0;
      for (int t = 1; t <= bd + 3; t++) begin
         @(posedge i_clock); #1;
         i_start = 1'b0;
         checks++;
         if (o_isRun !== run_at[t]) begin
            failures++;
            $display("FAIL %s isRun t=%0d got=%0b exp=%0b", name, t, o_isRun, run_at[t]);
         end
         checks++;
         if (o_batch_done !== (t == bd)) begin
            failures++;
            $display("FAIL %s batch_done t=%0d got=%0b exp=%0b", name, t, o_batch_done, (t == bd));
         end
         checks++;
         if (o_busy !== (t <= bd)) begin
            failures++;
            $display("FAIL %s busy t=%0d got=%0b exp=%0b", name, t, o_busy, (t <= bd));
         end
         if (t > bd) begin
            checks++;
            if (o_jobs_done !== CNT_W'(jobs) || o_timeout_err !== err) begin
               failures++;
               $display("FAIL %s idle_hold t=%0d jobs got=%0d exp=%0d err got=%0b exp=%0b",
                        name, t, o_jobs_done, jobs, o_timeout_err, err);
            end
         end
         if (t == abort_cycle) begin
            #2 i_reset_async = 1'b1;
            #1;
            checks++;
            if ({o_isRun, o_busy, o_batch_done, o_timeout_err} !== 4'b0 || o_jobs_done !== '0) begin
               failures++;
               $display("FAIL %s async_reset run=%0b busy=%0b bd=%0b err=%0b jobs=%0d exp all 0",
                        name, o_isRun, o_busy, o_batch_done, o_timeout_err, o_jobs_done);
            end
            i_done = 1'b0;
            @(posedge i_clock); #1;
            i_reset_async = 1'b0;
            exp_jobs = 0;
            exp_err  = 1'b0;
            return;
         end
         i_done = done_at[t] || (t >= bd && $urandom_range(1, 0) == 1);
         if (t == stray_t) begin
            i_start    = 1'b1;
            i_num_jobs = CNT_W'($urandom_range(5, 0));
         end
      end
      i_done  = 1'b0;
      i_start = 1'b0;
      exp_jobs = jobs;
      exp_err  = err;
      checks++;
      if (o_jobs_done !== CNT_W'(jobs)) begin
         failures++;
         $display("FAIL %s jobs_done got=%0d exp=%0d", name, o_jobs_done, jobs);
      end
      checks++;
      if (o_timeout_err !== err) begin
         failures++;
         $display("FAIL %s timeout_err got=%0b exp=%0b", name, o_timeout_err, err);
      end
   endtask

   // Idle cycles with optional stray i_done; nothing may move.
   task automatic idle_cycles(input string name, input int cycles, input bit stray_done);
      for (int t = 0; t < cycles; t++) begin
         i_done = stray_done;
         @(posedge i_clock); #1;
         checks++;
         if (o_busy !== 1'b0 || o_isRun !== 1'b0 || o_batch_done !== 1'b0 ||
             o_jobs_done !== CNT_W'(exp_jobs) || o_timeout_err !== exp_err) begin
            failures++;
            $display("FAIL %s idle busy=%0b run=%0b bd=%0b jobs=%0d exp=%0d err=%0b exp=%0b",
                     name, o_busy, o_isRun, o_batch_done, o_jobs_done, exp_jobs,
                     o_timeout_err, exp_err);
         end
      end
      i_done = 1'b0;
   endtask

   task automatic test_reset();
      #3 i_reset_async = 1'b1;
      #1;
      checks++;
      if ({o_isRun, o_busy, o_batch_done, o_timeout_err} !== 4'b0 || o_jobs_done !== '0) begin
         failures++;
         $display("FAIL reset_state run=%0b busy=%0b bd=%0b err=%0b jobs=%0d exp all 0",
                  o_isRun, o_busy, o_batch_done, o_timeout_err, o_jobs_done);
      end
      @(posedge i_clock); @(posedge i_clock); #1;
      i_reset_async = 1'b0;
      idle_cycles("reset_release", 2, 1'b0);
   endtask

   task automatic test_single_job();
      dly[0] = 2;
      run_batch("single_job", 1, 1'b0, 0);
   endtask

   task automatic test_batch3();
      dly[0] = 1; dly[1] = 2; dly[2] = 3;
      run_batch("batch3", 3, 1'b0, 0);
   endtask

   task automatic test_timeout();
      dly[0] = 99; dly[1] = 99;
      run_batch("timeout", 2, 1'b0, 0);
   endtask

   task automatic test_boundary();
      dly[0] = T;
      run_batch("expiry_done", 1, 1'b0, 0);
      dly[0] = T; dly[1] = T + 1;
      run_batch("expiry_then_timeout", 2, 1'b0, 0);
      run_batch("zero_jobs", 0, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      dly[0] = 2; dly[1] = 3; dly[2] = 4;
      run_batch("reset_mid_wait", 3, 1'b0, 5);
      idle_cycles("after_reset", 3, 1'b0);
      dly[0] = 2;
      run_batch("after_reset_batch", 1, 1'b0, 0);
   endtask

   task automatic test_ignore();
      idle_cycles("stray_done_idle", 3, 1'b1);
      dly[0] = 3; dly[1] = 1; dly[2] = 5;
      run_batch("stray_start_busy", 3, 1'b1, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         int n;
         n = int'($urandom_range(6, 0));
         for (int k = 0; k < 8; k++) begin
            dly[k] = ($urandom_range(4, 0) == 0) ? T : int'($urandom_range(T + 2, 1));
         end
         run_batch("random", n, 1'(($urandom_range(1, 0))), 0);
         idle_cycles("random_gap", int'($urandom_range(2, 0)), 1'(($urandom_range(1, 0))));
      end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_batch3();
      test_timeout();
      test_boundary();
      test_reset_mid();
      test_ignore();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
